// File: rtl/pc_pkg.sv
// pc_pkg: shared state type and mux-select encodings for the program-counter stage
package pc_pkg;
  typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} pc_state_t;
  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_J   = 2'b10;
  localparam logic [1:0] SEL_JR  = 2'b11;
  localparam int PC_INC = 4;
endpackage

// File: rtl/pc_sel_encode.sv
// pc_sel_encode: priority encoder of jr > jump > branch_taken into the next-PC mux select
module pc_sel_encode
  import pc_pkg::*;
(
  input  logic       jr,
  input  logic       jump,
  input  logic       branch_taken,
  output logic [1:0] sel
);
  assign sel = jr ? SEL_JR : jump ? SEL_J : branch_taken ? SEL_BR : SEL_SEQ;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, redirect/flush FSM and next-PC mux select driver.
// Define PC_ALIGN_CHECK_EN to halt on a misaligned redirect target instead of loading it.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int                FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             jr,
  input  logic [WIDTH-1:0] mux_y,
  output logic [1:0]       mux_sel,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             fetch_valid,
  output logic             flush,
  output logic             misalign
);
  pc_state_t state, state_nxt;
  logic [2:0] flush_cnt, cnt_nxt;
  logic [WIDTH-1:0] pc_nxt;
  logic [1:0] enc_sel;
  logic redirect, bad_tgt;
  pc_sel_encode u_enc (
    .jr           (jr),
    .jump         (jump),
    .branch_taken (branch_taken),
    .sel          (enc_sel)
  );
  assign pc_plus4    = pc + WIDTH'(PC_INC);
  assign mux_sel     = state == FLUSH ? SEL_SEQ : enc_sel;
  assign redirect    = state == RUN && (jr | jump | branch_taken);
  assign fetch_valid = state == RUN;
  assign flush       = redirect && !stall;
`ifdef PC_ALIGN_CHECK_EN
  assign bad_tgt  = mux_y[1:0] != 2'b00;
  assign misalign = state == HALT;
`else
  assign bad_tgt  = 1'b0;
  assign misalign = 1'b0;
`endif
  // stall freezes everything; HALT is only left through reset
  always_comb begin
    state_nxt = state;
    cnt_nxt   = flush_cnt;
    pc_nxt    = pc;
    if (!stall)
      unique case (state)
        BOOT: state_nxt = RUN;
        RUN: begin
          pc_nxt    = (redirect && bad_tgt) ? pc : mux_y;
          state_nxt = redirect ? (bad_tgt ? HALT : FLUSH) : RUN;
          cnt_nxt   = redirect ? 3'(FLUSH_CYCLES - 1) : flush_cnt;
        end
        FLUSH: begin
          pc_nxt    = mux_y;
          state_nxt = flush_cnt == 3'd0 ? RUN : FLUSH;
          cnt_nxt   = flush_cnt == 3'd0 ? flush_cnt : flush_cnt - 3'd1;
        end
        default: ;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc        <= RESET_VECTOR;
      state     <= BOOT;
      flush_cnt <= '0;
    end else begin
      pc        <= pc_nxt;
      state     <= state_nxt;
      flush_cnt <= cnt_nxt;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench with a bubble-counting reference model and the 4:1 next-PC mux
module tb_pc_sequencer;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam int FLUSH_CYCLES = 1;
  localparam logic [31:0] B_VAL = 32'h0000_0100;
  localparam logic [31:0] C_VAL = 32'h0000_2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, jr = 1'b0;
  logic [31:0] d_val = 32'h0000_3000;
  logic [31:0] mux_y, pc, pc_plus4;
  logic [1:0] mux_sel;
  logic fetch_valid, flush, misalign;

  always #5 clk = ~clk;

  assign mux_y = mux_sel == 2'b11 ? d_val : mux_sel == 2'b10 ? C_VAL :
                 mux_sel == 2'b01 ? B_VAL : pc_plus4;

  pc_sequencer #(.WIDTH(32), .RESET_VECTOR(32'h0), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jr           (jr),
    .mux_y        (mux_y),
    .mux_sel      (mux_sel),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fetch_valid  (fetch_valid),
    .flush        (flush),
    .misalign     (misalign)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] p4;
    logic [1:0]  sel;
    logic        fv;
    logic        fl;
    logic        mis;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;

  // reference model: booting flag, bubbles still owed, halted flag
  logic [31:0] m_pc;
  bit m_boot, m_halt;
  int m_bub;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  always @(negedge clk)
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc", pc, e.pc);
      chk("pc_plus4", pc_plus4, e.p4);
      chk("mux_sel", 32'(mux_sel), 32'(e.sel));
      chk("fetch_valid", 32'(fetch_valid), 32'(e.fv));
      chk("flush", 32'(flush), 32'(e.fl));
      chk("misalign", 32'(misalign), 32'(e.mis));
    end

  task automatic step(input logic rn, input logic s, input logic b, input logic j, input logic r);
    exp_t e;
    logic [31:0] tgt;
    bit taken;
    rst_n = rn; stall = s; branch_taken = b; jump = j; jr = r;
    if (!rn) begin
      m_pc = 32'h0; m_boot = 1; m_halt = 0; m_bub = 0;
    end
    e.sel = m_bub > 0 ? 2'd0 : r ? 2'd3 : j ? 2'd2 : b ? 2'd1 : 2'd0;
    e.fv  = !m_boot && !m_halt && m_bub == 0;
    taken = e.fv && (b || j || r) && !s;
    e.fl  = taken;
    e.pc  = m_pc;
    e.p4  = m_pc + 32'd4;
    e.mis = ALIGN && m_halt;
    tgt   = r ? d_val : j ? C_VAL : B_VAL;
    sb.push_back(e);
    @(posedge clk);
    if (rn && !s && !m_halt) begin
      if (m_boot) m_boot = 0;
      else if (m_bub > 0) begin m_pc = m_pc + 32'd4; m_bub--; end
      else if (taken) begin
        if (ALIGN && tgt[1:0] != 2'b00) m_halt = 1;
        else begin m_pc = tgt; m_bub = FLUSH_CYCLES; end
      end else m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  initial begin
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    d_val = 32'hFFFF_FFFC;
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    d_val = 32'h0000_3002;
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      d_val = $urandom_range(0, 15) == 0 ? ($urandom & 32'hFFFF_FFFF) : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
    end
    step(1, 0, 0, 0, 0);
    @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
